// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - request/broadcast bundle between execution units and the CDB arbiter
//
// Ports (interface signals):
//   req_valid     per-unit result valid
//   req_entry     per-unit ROB entry, unit i at [i*ENTRY_W +: ENTRY_W]
//   req_data      per-unit result, unit i at [i*DATA_W +: DATA_W]
//   req_ready     one-hot grant back to the units
//   cdb_integer   registered {entry, data} broadcast, zero when idle
//   cdb_grant_id  unit index behind the current broadcast, zero when idle
//   err_bad_entry sticky flag: an entry-0 request was consumed
// Modports: master = execution units side, slave = arbiter side.
interface cdb_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ENTRY_W = 6,
   parameter int DATA_W  = 32
);
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ*ENTRY_W-1:0] req_entry;
   logic [NUM_REQ*DATA_W-1:0]  req_data;
   logic [NUM_REQ-1:0]         req_ready;
   logic [ENTRY_W+DATA_W-1:0]  cdb_integer;
   logic [2:0]                 cdb_grant_id;
   logic                       err_bad_entry;

   modport master (
      output req_valid, req_entry, req_data,
      input  req_ready, cdb_integer, cdb_grant_id, err_bad_entry
   );

   modport slave (
      input  req_valid, req_entry, req_data,
      output req_ready, cdb_integer, cdb_grant_id, err_bad_entry
   );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - integer common data bus arbiter feeding the reorder buffer
//
// Grants one of NUM_REQ completed results per cycle and drives a registered
// {entry, data} broadcast one cycle after the handshake. Entry 0 is the idle
// encoding: such a request is consumed but never broadcast, and it raises the
// sticky err_bad_entry flag.
//
// Configuration macro CDB_ARB_RR_EN:
//   defined   - round-robin grant starting at a rotating priority pointer
//   undefined - fixed priority, lowest index wins (no pointer state)
//
// Ports:
//   clk    clock, all state updates on the rising edge
//   reset  synchronous active-high reset (wins over flush)
//   flush  drop all pending results this cycle, clear bus and pointer
//   bus    cdb_arbiter_if.slave: req_valid/req_entry/req_data in,
//          req_ready/cdb_integer/cdb_grant_id/err_bad_entry out
module cdb_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ENTRY_W = 6,
   parameter int DATA_W  = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          flush,
   cdb_arbiter_if.slave  bus
);
   localparam int BUS_W = ENTRY_W + DATA_W;

   logic [BUS_W-1:0]   cdb_q, cdb_d;
   logic [2:0]         id_q, id_d;
   logic               err_q, err_d;

   logic [2:0]         start;
   logic               hit_hi, hit_any, hit;
   logic [2:0]         idx_hi, idx_any, gnt_idx;
   logic [ENTRY_W-1:0] sel_entry;
   logic [DATA_W-1:0]  sel_data;
   logic [NUM_REQ-1:0] ready;

`ifdef CDB_ARB_RR_EN
   logic [2:0]         ptr_q, ptr_d;
   assign start = ptr_q;
`else
   assign start = 3'd0;
`endif

   always_comb begin
      hit_hi    = 1'b0;
      idx_hi    = 3'd0;
      hit_any   = 1'b0;
      idx_any   = 3'd0;
      sel_entry = '0;
      sel_data  = '0;
      ready     = '0;
      cdb_d     = '0;
      id_d      = 3'd0;
      err_d     = err_q;
`ifdef CDB_ARB_RR_EN
      ptr_d     = ptr_q;
`endif

      // Downward scan leaves the lowest valid index overall in idx_any and
      // the lowest valid index at/above the pointer in idx_hi; preferring
      // idx_hi gives the modulo-NUM_REQ upward search from the pointer.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (bus.req_valid[i]) begin
            hit_any = 1'b1;
            idx_any = 3'(i);
            if (3'(i) >= start) begin
               hit_hi = 1'b1;
               idx_hi = 3'(i);
            end
         end
      end

      // Reset and flush suppress the grant so nothing is consumed.
      hit     = hit_any && !flush && !reset;
      gnt_idx = hit_hi ? idx_hi : idx_any;

      for (int i = 0; i < NUM_REQ; i++) begin
         if (3'(i) == gnt_idx) begin
            sel_entry = bus.req_entry[i*ENTRY_W +: ENTRY_W];
            sel_data  = bus.req_data[i*DATA_W +: DATA_W];
            ready[i]  = hit;
         end
      end

      if (hit) begin
         if (sel_entry == '0) begin
            err_d = 1'b1;
         end else begin
            cdb_d = {sel_entry, sel_data};
            id_d  = gnt_idx;
         end
`ifdef CDB_ARB_RR_EN
         ptr_d = (gnt_idx == 3'(NUM_REQ - 1)) ? 3'd0 : gnt_idx + 3'd1;
`endif
      end

`ifdef CDB_ARB_RR_EN
      if (flush) begin
         ptr_d = 3'd0;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cdb_q <= '0;
         id_q  <= 3'd0;
         err_q <= 1'b0;
`ifdef CDB_ARB_RR_EN
         ptr_q <= 3'd0;
`endif
      end else begin
         cdb_q <= cdb_d;
         id_q  <= id_d;
         err_q <= err_d;
`ifdef CDB_ARB_RR_EN
         ptr_q <= ptr_d;
`endif
      end
   end

   assign bus.req_ready     = ready;
   assign bus.cdb_integer   = cdb_q;
   assign bus.cdb_grant_id  = id_q;
   assign bus.err_bad_entry = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
   localparam int N  = 4;
   localparam int EW = 6;
   localparam int DW = 32;
`ifdef CDB_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic clk;
   logic reset;
   logic flush;

   cdb_arbiter_if #(.NUM_REQ(N), .ENTRY_W(EW), .DATA_W(DW)) bus ();

   cdb_arbiter #(.NUM_REQ(N), .ENTRY_W(EW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_cmp;
   int n_err;

   // what the bench is presenting on each requester
   logic [N-1:0]  v_arr;
   logic [EW-1:0] e_arr [N];
   logic [DW-1:0] d_arr [N];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input bit v, input logic [EW-1:0] e, input logic [DW-1:0] d);
      v_arr[i] = v;
      e_arr[i] = e;
      d_arr[i] = d;
      bus.req_valid[i] = v;
      bus.req_entry[i*EW +: EW] = e;
      bus.req_data[i*DW +: DW] = d;
   endtask

   task automatic clear_all();
      for (int i = 0; i < N; i++) set_req(i, 1'b0, '0, '0);
   endtask

   task automatic do_reset();
      flush = 1'b0;
      reset = 1'b1;
      clear_all();
      tick();
      tick();
      reset = 1'b0;
   endtask

   // first valid unit at or after p, searching upward modulo N; -1 if none
   function automatic int model_pick(input logic [N-1:0] v, input int p);
      for (int k = 0; k < N; k++) begin
         if (v[(p + k) % N]) return (p + k) % N;
      end
      return -1;
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      for (int i = 0; i < N; i++) set_req(i, 1'b1, 6'(i + 1), $urandom);
      tick();
      tick();
      #1;
      n_cmp++; if (bus.cdb_integer !== '0) begin n_err++; $display("FAIL reset_cdb: got %h want 0", bus.cdb_integer); end
      n_cmp++; if (bus.cdb_grant_id !== 3'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", bus.cdb_grant_id); end
      n_cmp++; if (bus.err_bad_entry !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err_bad_entry); end
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b want 0000", bus.req_ready); end
      reset = 1'b0;
      clear_all();
      tick();
   endtask

   task automatic test_single();
      do_reset();
      set_req(2, 1'b1, 6'h05, 32'hDEADBEEF);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
      tick();
      n_cmp++; if (bus.cdb_integer !== {6'h05, 32'hDEADBEEF}) begin n_err++; $display("FAIL single_cdb: got %h want %h", bus.cdb_integer, {6'h05, 32'hDEADBEEF}); end
      n_cmp++; if (bus.cdb_grant_id !== 3'd2) begin n_err++; $display("FAIL single_id: got %0d want 2", bus.cdb_grant_id); end
      set_req(2, 1'b0, '0, '0);
      tick();
      n_cmp++; if (bus.cdb_integer !== '0) begin n_err++; $display("FAIL single_idle: got %h want 0", bus.cdb_integer); end
      n_cmp++; if (bus.cdb_grant_id !== 3'd0) begin n_err++; $display("FAIL single_idle_id: got %0d want 0", bus.cdb_grant_id); end
   endtask

   task automatic test_round_robin();
      int exp_g;
      logic [N-1:0] exp_rdy;
      logic [EW+DW-1:0] exp_bus;
      do_reset();
      for (int u = 0; u < N; u++) set_req(u, 1'b1, 6'(u + 1), $urandom);
      for (int c = 0; c < 5; c++) begin
         #1;
         exp_g   = RR ? (c % N) : 0;
         exp_rdy = 4'(1) << exp_g;
         exp_bus = {6'(exp_g + 1), d_arr[exp_g]};
         n_cmp++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rr_ready[%0d]: got %b want %b", c, bus.req_ready, exp_rdy); end
         tick();
         n_cmp++; if (bus.cdb_integer !== exp_bus) begin n_err++; $display("FAIL rr_cdb[%0d]: got %h want %h", c, bus.cdb_integer, exp_bus); end
         n_cmp++; if (bus.cdb_grant_id !== 3'(exp_g)) begin n_err++; $display("FAIL rr_id[%0d]: got %0d want %0d", c, bus.cdb_grant_id, exp_g); end
      end
      clear_all();
   endtask

   task automatic test_entry0();
      do_reset();
      set_req(1, 1'b1, 6'h00, 32'h0000_1234);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL e0_ready: got %b want 0010", bus.req_ready); end
      tick();
      set_req(1, 1'b0, '0, '0);
      n_cmp++; if (bus.cdb_integer !== '0) begin n_err++; $display("FAIL e0_cdb: got %h want 0", bus.cdb_integer); end
      n_cmp++; if (bus.cdb_grant_id !== 3'd0) begin n_err++; $display("FAIL e0_id: got %0d want 0", bus.cdb_grant_id); end
      n_cmp++; if (bus.err_bad_entry !== 1'b1) begin n_err++; $display("FAIL e0_err: got %b want 1", bus.err_bad_entry); end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_cmp++; if (bus.err_bad_entry !== 1'b1) begin n_err++; $display("FAIL e0_sticky[%0d]: got %b want 1", c, bus.err_bad_entry); end
         n_cmp++; if (bus.cdb_integer !== '0) begin n_err++; $display("FAIL e0_quiet[%0d]: got %h want 0", c, bus.cdb_integer); end
      end
   endtask

   task automatic test_flush();
      logic [DW-1:0] d1;
      do_reset();
      d1 = $urandom;
      set_req(1, 1'b1, 6'h0A, d1);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0010) begin n_err++; $display("FAIL fl_pre_ready: got %b want 0010", bus.req_ready); end
      tick();
      set_req(1, 1'b0, '0, '0);
      set_req(0, 1'b1, 6'h11, $urandom);
      set_req(3, 1'b1, 6'h13, $urandom);
      flush = 1'b1;
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL fl_ready: got %b want 0000", bus.req_ready); end
      n_cmp++; if (bus.cdb_integer !== {6'h0A, d1}) begin n_err++; $display("FAIL fl_inflight: got %h want %h", bus.cdb_integer, {6'h0A, d1}); end
      tick();
      flush = 1'b0;
      n_cmp++; if (bus.cdb_integer !== '0) begin n_err++; $display("FAIL fl_cdb: got %h want 0", bus.cdb_integer); end
      n_cmp++; if (bus.cdb_grant_id !== 3'd0) begin n_err++; $display("FAIL fl_id: got %0d want 0", bus.cdb_grant_id); end
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0001) begin n_err++; $display("FAIL fl_post_ready: got %b want 0001", bus.req_ready); end
      tick();
      n_cmp++; if (bus.cdb_integer !== {6'h11, d_arr[0]}) begin n_err++; $display("FAIL fl_post_cdb: got %h want %h", bus.cdb_integer, {6'h11, d_arr[0]}); end
      clear_all();
   endtask

   task automatic test_reset_midstream();
      logic [DW-1:0] d0;
      do_reset();
      set_req(1, 1'b1, 6'h00, $urandom);
      tick();
      set_req(1, 1'b0, '0, '0);
      d0 = $urandom;
      set_req(0, 1'b1, 6'h3F, d0);
      tick();
      set_req(0, 1'b0, '0, '0);
      n_cmp++; if (bus.cdb_integer !== {6'h3F, d0}) begin n_err++; $display("FAIL rm_cdb_pre: got %h want %h", bus.cdb_integer, {6'h3F, d0}); end
      n_cmp++; if (bus.err_bad_entry !== 1'b1) begin n_err++; $display("FAIL rm_err_pre: got %b want 1", bus.err_bad_entry); end
      reset = 1'b1;
      set_req(2, 1'b1, 6'h22, $urandom);
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL rm_ready0: got %b want 0000", bus.req_ready); end
      tick();
      n_cmp++; if (bus.cdb_integer !== '0) begin n_err++; $display("FAIL rm_cdb: got %h want 0", bus.cdb_integer); end
      n_cmp++; if (bus.cdb_grant_id !== 3'd0) begin n_err++; $display("FAIL rm_id: got %0d want 0", bus.cdb_grant_id); end
      n_cmp++; if (bus.err_bad_entry !== 1'b0) begin n_err++; $display("FAIL rm_err: got %b want 0", bus.err_bad_entry); end
      #1;
      n_cmp++; if (bus.req_ready !== 4'b0000) begin n_err++; $display("FAIL rm_ready1: got %b want 0000", bus.req_ready); end
      tick();
      reset = 1'b0;
      clear_all();
   endtask

   task automatic test_holdoff();
      int exp_g;
      bit found;
      logic [N-1:0] exp_rdy;
      logic [EW+DW-1:0] exp_bus;
      logic [DW-1:0] d3;
      do_reset();
      d3 = $urandom;
      set_req(3, 1'b1, 6'h33, d3);
      for (int u = 0; u < 3; u++) set_req(u, 1'b1, 6'($urandom_range(1, 63)), $urandom);
      found = 1'b0;
      for (int c = 0; c < N; c++) begin
         #1;
         exp_g   = RR ? c : 0;
         exp_rdy = 4'(1) << exp_g;
         exp_bus = (exp_g == 3) ? {6'h33, d3} : {e_arr[exp_g], d_arr[exp_g]};
         n_cmp++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL ho_ready[%0d]: got %b want %b", c, bus.req_ready, exp_rdy); end
         if (bus.req_ready[3]) found = 1'b1;
         tick();
         n_cmp++; if (bus.cdb_integer !== exp_bus) begin n_err++; $display("FAIL ho_cdb[%0d]: got %h want %h", c, bus.cdb_integer, exp_bus); end
         if (exp_g < 3) set_req(exp_g, 1'b1, 6'($urandom_range(1, 63)), $urandom);
      end
      n_cmp++; if (found !== RR) begin n_err++; $display("FAIL ho_fair: unit3 granted=%b want %b", found, RR); end
      clear_all();
   endtask

   task automatic test_random();
      int g;
      int mptr;
      bit merr;
      logic [N-1:0] exp_rdy;
      logic [EW+DW-1:0] exp_bus;
      logic [2:0] exp_id;
      do_reset();
      mptr = 0;
      merr = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         for (int u = 0; u < N; u++) begin
            if (!v_arr[u] && $urandom_range(0, 2) == 0)
               set_req(u, 1'b1, ($urandom_range(0, 15) == 0) ? 6'h00 : 6'($urandom_range(1, 63)), $urandom);
         end
         flush = ($urandom_range(0, 15) == 0);
         #1;
         g       = flush ? -1 : model_pick(v_arr, mptr);
         exp_rdy = (g < 0) ? 4'b0000 : (4'(1) << g);
         exp_bus = '0;
         exp_id  = 3'd0;
         if (g >= 0) begin
            if (e_arr[g] == '0) merr = 1'b1;
            else begin
               exp_bus = {e_arr[g], d_arr[g]};
               exp_id  = 3'(g);
            end
            mptr = RR ? ((g + 1) % N) : 0;
         end
         if (flush) mptr = 0;
         n_cmp++; if (bus.req_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, bus.req_ready, exp_rdy); end
         tick();
         n_cmp++; if (bus.cdb_integer !== exp_bus) begin n_err++; $display("FAIL rnd_cdb[%0d]: got %h want %h", cyc, bus.cdb_integer, exp_bus); end
         n_cmp++; if (bus.cdb_grant_id !== exp_id) begin n_err++; $display("FAIL rnd_id[%0d]: got %0d want %0d", cyc, bus.cdb_grant_id, exp_id); end
         n_cmp++; if (bus.err_bad_entry !== merr) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want %b", cyc, bus.err_bad_entry, merr); end
         if (g >= 0) set_req(g, 1'b0, '0, '0);
      end
      flush = 1'b0;
      clear_all();
   endtask

   initial begin
      clk   = 1'b0;
      reset = 1'b1;
      flush = 1'b0;
      n_cmp = 0;
      n_err = 0;
      clear_all();
      test_reset();
      test_single();
      test_round_robin();
      test_entry0();
      test_flush();
      test_reset_midstream();
      test_holdoff();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
